// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor sequencer: instruction format,
// opcodes, FSM state encoding and field accessors.
package simple_proc_pkg;

  localparam int unsigned INSTR_W = 9;

  // Instruction word layout: III XXX YYY
  localparam int unsigned III_HI = 8;
  localparam int unsigned III_LO = 6;
  localparam int unsigned XXX_HI = 5;
  localparam int unsigned XXX_LO = 3;
  localparam int unsigned YYY_HI = 2;
  localparam int unsigned YYY_LO = 0;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_IMM_LATCH,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } state_t;

  function automatic logic [2:0] instr_iii(input logic [INSTR_W-1:0] instr);
    return instr[III_HI:III_LO];
  endfunction

  function automatic logic [2:0] instr_xxx(input logic [INSTR_W-1:0] instr);
    return instr[XXX_HI:XXX_LO];
  endfunction

  function automatic logic [2:0] instr_yyy(input logic [INSTR_W-1:0] instr);
    return instr[YYY_HI:YYY_LO];
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Watchdog for the sequencer WAIT state.
// Ports: clk, rst_n (async active-low), clear (restart the count; the clearing
// cycle is the Run cycle and counts as cycle 1), enable (count this cycle),
// expired (combinational: this enabled cycle is the last one before timeout).
module seq_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count_q;

  // Count cycles since the Run pulse, saturating at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= CNT_W'(1);
    end else if (enable && (count_q != CNT_W'(TIMEOUT))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Expiring here makes the error visible exactly TIMEOUT cycles after Run
  assign expired = enable && (count_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/proc_sequencer.sv
// Instruction sequencer: fetches 9-bit instructions (and mvi immediates) from
// a program ROM, issues them to the processor with a Run pulse and waits for
// Done, guarded by a watchdog.
// Ports: Clock, Resetn (async active-low), Start/Stop (level-sampled controls),
// Rom_addr/Rom_rd (ROM request, decoded from state and PC), Rom_data (ROM data
// one cycle after Rom_rd), DIN/Run (to processor), Done (from processor),
// Busy/Halted/Error (status), Instr_count (completed instructions, saturating).
module proc_sequencer
  import simple_proc_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Stop,
  output logic [ADDR_W-1:0]  Rom_addr,
  output logic               Rom_rd,
  input  logic [INSTR_W-1:0] Rom_data,
  output logic [INSTR_W-1:0] DIN,
  output logic               Run,
  input  logic               Done,
  output logic               Busy,
  output logic               Halted,
  output logic               Error,
  output logic [7:0]         Instr_count
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [INSTR_W-1:0]   imm_q, imm_d;
  logic [INSTR_W-1:0]   din_d;
  logic [7:0]           cnt_d;
  logic                 stop_q, stop_d;
  logic                 wd_clear, wd_en, wd_expired;

  function automatic logic is_busy(input state_t s);
    return !((s == S_IDLE) || (s == S_HALT) || (s == S_ERROR));
  endfunction

  seq_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (Clock),
    .rst_n  (Resetn),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_expired)
  );

  // ROM request is a pure decode of the current state and PC
  assign Rom_rd   = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign Rom_addr = pc_q;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    din_d    = DIN;
    cnt_d    = Instr_count;
    stop_d   = stop_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;

    if (is_busy(state_q) && Stop) begin
      stop_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_HALT, S_ERROR: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          cnt_d   = 8'd0;
          stop_d  = 1'b0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = Rom_data;
        case (instr_iii(Rom_data))
          OP_HALT: state_d = S_HALT;
          OP_MVI: begin
            din_d   = Rom_data;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH_IMM;
          end
          default: begin
            din_d   = Rom_data;
            state_d = S_ISSUE;
          end
        endcase
      end
      S_FETCH_IMM: state_d = S_IMM_LATCH;
      S_IMM_LATCH: begin
        imm_d   = Rom_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_clear = 1'b1;
        din_d    = (instr_iii(ir_q) == OP_MVI) ? imm_q : ir_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        // Done takes priority over a simultaneous watchdog expiry
        if (Done) begin
          pc_d = pc_q + ADDR_W'(1);
          if (Instr_count != 8'hFF) begin
            cnt_d = Instr_count + 8'd1;
          end
          state_d = (stop_q || Stop) ? S_IDLE : S_FETCH;
        end else if (wd_expired) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      imm_q       <= '0;
      stop_q      <= 1'b0;
      DIN         <= '0;
      Instr_count <= 8'd0;
      Run         <= 1'b0;
      Busy        <= 1'b0;
      Halted      <= 1'b0;
      Error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imm_q       <= imm_d;
      stop_q      <= stop_d;
      DIN         <= din_d;
      Instr_count <= cnt_d;
      Run         <= (state_d == S_ISSUE);
      Busy        <= is_busy(state_d);
      Halted      <= (state_d == S_HALT);
      Error       <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: a cycle-by-cycle vector table for a
// short mv/halt program, then directed sequences for mvi, watchdog, stop,
// address wrap (second instance with ADDR_W=2) and reset mid-instruction.
module tb_proc_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (ADDR_W=5, TIMEOUT=16)
  logic       start_a = 1'b0, stop_a = 1'b0, done_a;
  logic [4:0] rom_addr_a;
  logic       rom_rd_a, run_a, busy_a, halted_a, error_a;
  logic [8:0] rom_data_a = 9'h000, din_a;
  logic [7:0] icount_a;
  logic [8:0] rom_a [32];

  // Instance B: ADDR_W=2
  logic       start_b = 1'b0, stop_b = 1'b0, done_b;
  logic [1:0] rom_addr_b;
  logic       rom_rd_b, run_b, busy_b, halted_b, error_b;
  logic [8:0] rom_data_b = 9'h000, din_b;
  logic [7:0] icount_b;
  logic [8:0] rom_b [4];

  int done_lat   = 3;
  bit never_done = 1'b0;
  int dcnt_a, dcnt_b;
  int runs_a = 0;
  int runs_b = 0;

  int checks   = 0;
  int failures = 0;

  proc_sequencer dut_a (
    .Clock(clk), .Resetn(rst_n), .Start(start_a), .Stop(stop_a),
    .Rom_addr(rom_addr_a), .Rom_rd(rom_rd_a), .Rom_data(rom_data_a),
    .DIN(din_a), .Run(run_a), .Done(done_a), .Busy(busy_a),
    .Halted(halted_a), .Error(error_a), .Instr_count(icount_a)
  );

  proc_sequencer #(.ADDR_W(2), .TIMEOUT(16)) dut_b (
    .Clock(clk), .Resetn(rst_n), .Start(start_b), .Stop(stop_b),
    .Rom_addr(rom_addr_b), .Rom_rd(rom_rd_b), .Rom_data(rom_data_b),
    .DIN(din_b), .Run(run_b), .Done(done_b), .Busy(busy_b),
    .Halted(halted_b), .Error(error_b), .Instr_count(icount_b)
  );

  // ROM models: data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (rom_rd_a) rom_data_a <= rom_a[rom_addr_a];
    if (rom_rd_b) rom_data_b <= rom_b[rom_addr_b];
  end

  // Processor models: Done pulses done_lat cycles after Run
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_a <= 0;
      done_a <= 1'b0;
    end else begin
      done_a <= 1'b0;
      if (run_a && !never_done) dcnt_a <= done_lat - 1;
      else if (dcnt_a != 0) begin
        dcnt_a <= dcnt_a - 1;
        if (dcnt_a == 1) done_a <= 1'b1;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_b <= 0;
      done_b <= 1'b0;
    end else begin
      done_b <= 1'b0;
      if (run_b) dcnt_b <= 2;
      else if (dcnt_b != 0) begin
        dcnt_b <= dcnt_b - 1;
        if (dcnt_b == 1) done_b <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (run_a) runs_a <= runs_a + 1;
    if (run_b) runs_b <= runs_b + 1;
  end

  typedef struct packed {
    logic       rom_rd;
    logic [4:0] rom_addr;
    logic       run;
    logic [8:0] din;
    logic       busy;
    logic       halted;
    logic       error;
    logic [7:0] icount;
  } obs_t;

  typedef struct {
    logic start;
    logic stop;
    obs_t exp;
  } vec_t;

  function automatic obs_t mk(input logic rd, input logic [4:0] addr, input logic run,
                              input logic [8:0] din, input logic busy, input logic halted,
                              input logic error, input logic [7:0] icount);
    obs_t o;
    o.rom_rd = rd; o.rom_addr = addr; o.run = run; o.din = din;
    o.busy = busy; o.halted = halted; o.error = error; o.icount = icount;
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(rom_rd_a, rom_addr_a, run_a, din_a, busy_a, halted_a, error_a, icount_a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom_a();
    for (int i = 0; i < 32; i++) rom_a[i] = 9'h1C0;
  endtask

  vec_t vecs[10];
  int   n;
  int   r0;

  initial begin
    clear_rom_a();
    rom_b[0] = 9'h03A; rom_b[1] = 9'h00B; rom_b[2] = 9'h0D1; rom_b[3] = 9'h050;

    repeat (2) tick();
    check("reset_outputs", 32'(obs_a()), 32'(mk(0, 0, 0, 9'h000, 0, 0, 0, 8'd0)));
    rst_n = 1'b1;
    tick();

    // mv R0,R1 then halt; Done 3 cycles after Run; Start during WAIT ignored
    rom_a[0] = 9'h001; rom_a[1] = 9'h1C0;
    vecs[0] = '{1'b1, 1'b0, mk(1, 0, 0, 9'h000, 1, 0, 0, 8'd0)}; // FETCH
    vecs[1] = '{1'b0, 1'b0, mk(0, 0, 0, 9'h000, 1, 0, 0, 8'd0)}; // DECODE
    vecs[2] = '{1'b0, 1'b0, mk(0, 0, 1, 9'h001, 1, 0, 0, 8'd0)}; // ISSUE
    vecs[3] = '{1'b1, 1'b0, mk(0, 0, 0, 9'h001, 1, 0, 0, 8'd0)}; // WAIT
    vecs[4] = '{1'b1, 1'b0, mk(0, 0, 0, 9'h001, 1, 0, 0, 8'd0)}; // WAIT
    vecs[5] = '{1'b0, 1'b0, mk(0, 0, 0, 9'h001, 1, 0, 0, 8'd0)}; // WAIT, Done
    vecs[6] = '{1'b0, 1'b0, mk(1, 1, 0, 9'h001, 1, 0, 0, 8'd1)}; // FETCH pc=1
    vecs[7] = '{1'b0, 1'b0, mk(0, 1, 0, 9'h001, 1, 0, 0, 8'd1)}; // DECODE
    vecs[8] = '{1'b0, 1'b0, mk(0, 1, 0, 9'h001, 0, 1, 0, 8'd1)}; // HALT
    vecs[9] = '{1'b0, 1'b0, mk(0, 1, 0, 9'h001, 0, 1, 0, 8'd1)}; // HALT
    r0 = runs_a;
    for (int i = 0; i < 10; i++) begin
      start_a = vecs[i].start;
      stop_a  = vecs[i].stop;
      tick();
      check($sformatf("vec%0d", i), 32'(obs_a()), 32'(vecs[i].exp));
    end
    start_a = 1'b0;
    check("mv_run_count", 32'(runs_a - r0), 32'd1);

    // mvi R2, #0x155 then halt: 5-cycle latency, immediate on DIN during WAIT
    clear_rom_a();
    rom_a[0] = 9'h050; rom_a[1] = 9'h155;
    start_a = 1'b1; tick(); start_a = 1'b0; n = 1;
    while (!run_a && n < 20) begin tick(); n++; end
    check("mvi_latency", 32'(n), 32'd5);
    check("mvi_issue_din", 32'(din_a), 32'h050);
    tick();
    check("mvi_wait_din", 32'(din_a), 32'h155);
    n = 0;
    while (!halted_a && n < 50) begin tick(); n++; end
    check("mvi_halted", 32'(halted_a), 32'd1);
    check("mvi_count", 32'(icount_a), 32'd1);
    check("mvi_pc", 32'(rom_addr_a), 32'd2);

    // Done in the same cycle the watchdog expires: Done wins
    clear_rom_a();
    rom_a[0] = 9'h080;
    done_lat = 15;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!halted_a && !error_a && n < 60) begin tick(); n++; end
    check("tie_error", 32'(error_a), 32'd0);
    check("tie_count", 32'(icount_a), 32'd1);

    // Done one cycle too late: error, late Done ignored
    done_lat = 16;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!halted_a && !error_a && n < 60) begin tick(); n++; end
    repeat (3) tick();
    check("late_error", 32'(error_a), 32'd1);
    check("late_count", 32'(icount_a), 32'd0);
    done_lat = 3;

    // Watchdog: second instruction never completes
    clear_rom_a();
    rom_a[0] = 9'h001; rom_a[1] = 9'h080;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!run_a && n < 20) begin tick(); n++; end
    tick();
    never_done = 1'b1;
    n = 0;
    while (!run_a && n < 20) begin tick(); n++; end
    check("wd_second_run", 32'(din_a), 32'h080);
    n = 0;
    while (!error_a && n < 40) begin tick(); n++; end
    check("wd_cycles", 32'(n), 32'd16);
    check("wd_busy", 32'(busy_a), 32'd0);
    check("wd_pc_held", 32'(rom_addr_a), 32'd1);
    check("wd_din_held", 32'(din_a), 32'h080);
    never_done = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("wd_restart", 32'({error_a, rom_rd_a, rom_addr_a}), 32'({1'b0, 1'b1, 5'd0}));
    n = 0;
    while (!halted_a && n < 60) begin tick(); n++; end
    check("wd_restart_halt", 32'({halted_a, icount_a}), 32'({1'b1, 8'd2}));

    // Stop during the ROM read of instruction 2 of 4 adds
    clear_rom_a();
    for (int i = 0; i < 4; i++) rom_a[i] = 9'h080;
    r0 = runs_a;
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!(rom_rd_a && rom_addr_a == 5'd1) && n < 30) begin tick(); n++; end
    check("stop_fetch2_seen", 32'(rom_rd_a), 32'd1);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    n = 0;
    while (busy_a && n < 40) begin tick(); n++; end
    repeat (10) tick();
    check("stop_state", 32'({busy_a, halted_a, error_a}), 32'd0);
    check("stop_count", 32'(icount_a), 32'd2);
    check("stop_pc", 32'(rom_addr_a), 32'd2);
    check("stop_runs", 32'(runs_a - r0), 32'd2);

    // ADDR_W=2: mvi at address 3 takes its immediate from address 0
    start_b = 1'b1; tick(); start_b = 1'b0;
    n = 0;
    while (!(run_b && din_b == 9'h050) && n < 100) begin tick(); n++; end
    check("wrap_mvi_issue", 32'(din_b), 32'h050);
    tick();
    check("wrap_imm", 32'(din_b), 32'h03A);
    stop_b = 1'b1; tick(); stop_b = 1'b0;
    n = 0;
    while (busy_b && n < 40) begin tick(); n++; end
    check("wrap_pc", 32'(rom_addr_b), 32'd1);
    check("wrap_count", 32'(icount_b), 32'd4);
    check("wrap_runs", 32'(runs_b), 32'd4);

    // Reset asserted during WAIT abandons the instruction
    start_a = 1'b1; tick(); start_a = 1'b0;
    n = 0;
    while (!run_a && n < 20) begin tick(); n++; end
    tick();
    check("rst_in_wait", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(obs_a()), 32'(mk(0, 0, 0, 9'h000, 0, 0, 0, 8'd0)));
    repeat (2) tick();
    rst_n = 1'b1;
    r0 = runs_a;
    repeat (12) tick();
    check("rst_no_rerun", 32'(runs_a - r0), 32'd0);
    check("rst_idle", 32'(obs_a()), 32'(mk(0, 0, 0, 9'h000, 0, 0, 0, 8'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 5, program ROM address width.
REQ-002 Parameter TIMEOUT, default 16, maximum cycles from Run to Done before error.
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Resetn  input  1  asynchronous reset, active-low.
REQ-005 Start  input  1  level-sampled; begins execution from address 0.
REQ-006 Stop  input  1  level-sampled; requests a halt at the next instruction boundary.
REQ-007 Rom_addr  output  ADDR_W  program ROM address.
REQ-008 Rom_rd  output  1  ROM read strobe; data is valid on Rom_data one cycle later.
REQ-009 Rom_data  input  9  ROM read data, format III XXX YYY.
REQ-010 DIN  output  9  instruction or immediate word to the processor.
REQ-011 Run  output  1  one-cycle issue pulse to the processor.
REQ-012 Done  input  1  processor completion pulse.
REQ-013 Busy  output  1  high in every state except IDLE, HALT and ERROR.
REQ-014 Halted  output  1  high in HALT.
REQ-015 Error  output  1  high in ERROR.
REQ-016 Instr_count  output  8  number of completed instructions; saturates at 255.

Function
REQ-017 Opcodes SHALL be: mv=000, mvi=001, add=010, sub=011, halt=111; opcodes 100 to 110 SHALL be issued like mv.
REQ-018 The FSM SHALL have the states IDLE, FETCH, DECODE, FETCH_IMM, IMM_LATCH, ISSUE, WAIT, HALT and ERROR.
REQ-019 IDLE/HALT/ERROR: Start=1 SHALL clear PC and Instr_count, clear the stop latch and go to FETCH. Start SHALL be ignored in all other states.
REQ-020 FETCH: Rom_rd=1 and Rom_addr=PC; next state DECODE.
REQ-021 DECODE SHALL latch Rom_data into IR, then branch:
- opcode halt: go to HALT, with PC unchanged and no Run pulse.
- opcode mvi: PC=PC+1, go to FETCH_IMM.
- any other opcode: go to ISSUE.
REQ-022 FETCH_IMM: Rom_rd=1 and Rom_addr=PC; next state IMM_LATCH.
REQ-023 IMM_LATCH SHALL latch Rom_data into IMM; next state ISSUE.
REQ-024 ISSUE SHALL drive Run=1 for exactly one cycle with DIN=IR, clear the watchdog and go to WAIT.
REQ-025 WAIT behaviour:
- DIN SHALL be IMM for mvi and IR otherwise, and SHALL stay stable until Done.
- Run SHALL be 0.
REQ-026 WAIT, Done=1: PC=PC+1 and Instr_count increments (saturating). The next state SHALL be IDLE if the stop latch is set, otherwise FETCH.
REQ-027 WAIT, watchdog reaches TIMEOUT without Done: go to ERROR; PC and IR are held for debug.
REQ-028 Done SHALL be ignored in every state except WAIT.
REQ-029 The stop latch SHALL set when Stop=1 in any Busy state. Stop alone SHALL never abort a fetch or an issued instruction.
REQ-030 Done and the watchdog expiring in the same cycle: Done SHALL win.
REQ-031 PC SHALL wrap from 2^ADDR_W-1 to 0. An mvi at the last address SHALL fetch its immediate from address 0.
REQ-032 Outside FETCH and FETCH_IMM, Rom_rd SHALL be 0 and Rom_addr SHALL equal PC.
REQ-033 Latency from Start to the first Run: 3 cycles for a non-mvi instruction, 5 cycles for mvi.

Reset
REQ-034 Resetn=0 SHALL immediately force:
- state = IDLE
- PC, IR, IMM, watchdog, Instr_count and the stop latch = 0
- Run, Rom_rd, Busy, Halted and Error = 0
- DIN = 0 and Rom_addr = 0
REQ-035 Reset asserted mid-instruction SHALL abandon it with no Run re-issue after release. Execution SHALL resume only on a new Start.

Structure
REQ-036 A shared package simple_proc_pkg SHALL hold:
- the opcode constants
- the FSM state enumeration
- the instruction width of 9
- the field slices III, XXX and YYY
REQ-037 The watchdog SHALL be a sub-module seq_timeout_counter with ports clear, enable and expired, parameterised by TIMEOUT.
REQ-038 All outputs SHALL be registered except Rom_addr and Rom_rd, which may be decoded from state and PC.

Verification
REQ-039 Program mv R0,R1 (0_000_000_001), then halt. Start; processor model returns Done 3 cycles after Run -> exactly one Run with DIN=0x001, Instr_count=1, Halted=1, PC=1.
REQ-040 Program mvi R2 then immediate 0x155, then halt -> Run with DIN=0x050, DIN=0x155 during WAIT, Instr_count=1, Halted at PC=2.
REQ-041 Processor model never returns Done -> Error=1 exactly TIMEOUT cycles after Run; Busy=0; Start then restarts from PC=0 with Error=0.
REQ-042 Stop pulsed during the ROM read of instruction 2 of 4 add instructions -> instruction 2 still completes; then IDLE with Instr_count=2 and no further Run.
REQ-043 ADDR_W=2, mvi placed at address 3 -> immediate read from address 0, PC ends at 1; and Resetn asserted during WAIT -> all outputs 0 asynchronously and no Run after release.
